sha2_msg_expander: RTL and testbench
====================================

# sha2_msg_expander

Parametrised SHA-2 message schedule that accepts one 512/1024-bit message block as 16 words and emits the full Wt sequence (64 rounds for SHA-256, 80 for SHA-512) to the hash core, one word per accepted transfer. It is the next generation of the message-schedule stage. It is generalised in word width and round count and adds valid/ready flow control on both sides, round indexing and completion signalling. It sits between the padding/input buffer and the compression core.

## Interface
- WORD_W, 32, word width. Legal values: 32 (SHA-256 σ constants) or 64 (SHA-512 σ constants).
- ROUNDS, 64, number of Wt words emitted per block. Must be > 16. Nominally 64 for WORD_W=32 and 80 for WORD_W=64.
- RIDX_W, $clog2(ROUNDS), width of the round index.
- clk  in  1  single clock; all state is clocked on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- data_in  in  WORD_W  message word M_t, t = 0..15, most-significant word first.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  block can accept a word this cycle.
- w_out  out  WORD_W  registered schedule word Wt.
- w_valid  out  1  w_out holds a word not yet taken.
- w_ready  in  1  hash core takes w_out this cycle.
- round_idx  out  RIDX_W  index t of the word currently on w_out.
- busy  out  1  a block is in progress: state ≠ IDLE, or w_valid = 1.
- done  out  1  one-cycle pulse on the cycle after word ROUNDS-1 is taken.
- abort  in  1  only present with MSG_EXP_ABORT_EN.

## Operation
- State: 16-entry window win[0..15] (win[15] newest), round counter rnd, FSM with states IDLE, LOAD, EXPAND.
- Output slot free: `slot_free = !w_valid || w_ready`.
- data_ready = slot_free in IDLE or LOAD, 0 in EXPAND.
- IDLE: a word is accepted when data_valid && data_ready. On acceptance go to LOAD, with load count 1.
- LOAD, on each accepted word:
  - shift data_in into win[15];
  - w_out <= data_in, w_valid <= 1, round_idx <= load count;
  - after the 16th word go to EXPAND.
- EXPAND: when slot_free, compute W = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], modulo 2^WORD_W, with carries discarded.
  - Shift W into the window and issue it on w_out with round_idx incremented.
  - After word ROUNDS-1 is issued, stop computing.
- σ functions:
  - WORD_W=32: σ0 = ROTR7^ROTR18^SHR3, σ1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: σ0 = ROTR1^ROTR8^SHR7, σ1 = ROTR19^ROTR61^SHR6.
- Completion:
  - When word ROUNDS-1 is taken (w_valid && w_ready), clear w_valid, pulse done next cycle and return to IDLE.
  - A new block's first word may be accepted in that same cycle, because slot_free = 1 and the state returns to IDLE.
- data_valid while data_ready = 0 is ignored; the source must hold the word.
- Reset values: w_out = 0, w_valid = 0, round_idx = 0, done = 0, busy = 0, window = 0, state = IDLE. After reset data_ready = 1.
- Reset asserted mid-block discards the block with no done pulse.

## Timing
- Input word accepted at edge n appears on w_out after edge n, i.e. valid in cycle n+1.
- EXPAND throughput: one word per cycle while w_ready = 1.
- Unstalled block: 16 load cycles plus ROUNDS-16 expand cycles. The final word is taken ROUNDS cycles after the first acceptance when w_ready is held high.
- Backpressure: while w_valid && !w_ready, w_out, round_idx, the window and rnd hold, and data_ready = 0.
- The σ/adder path is a single combinational stage from window registers to w_out; no internal pipelining.

## Configuration
- MSG_EXP_ABORT_EN defined:
  - the abort port exists;
  - abort = 1 at an edge forces IDLE, w_valid = 0, round_idx = 0 and a cleared window, with no done pulse;
  - abort has priority over a simultaneous input acceptance or output transfer.
- Not defined: no abort port; a block can only be terminated by reset.

## Structure
- Package sha2_pkg:
  - WORD_W-indexed σ rotate/shift constants;
  - FSM state enum (IDLE, LOAD, EXPAND);
  - window depth constant (16).
- Sub-module sha2_sigma: combinational, parameter WORD_W, a mode select for σ0/σ1, one instance per σ.
- The 4-operand modulo adder stays in-line; carry_lookahead_adder instances are permitted but not required.

## Test plan
- "abc" padded SHA-256 block: W0 = 0x61626380, W1–W14 = 0, W15 = 0x00000018, w_ready = 1.
  - Required: 64 words, W16 = 0x61626380, W17 = 0x000F0000.
  - Remaining words match the reference model, then a done pulse 1 cycle after round 63 is taken.
- WORD_W = 64, ROUNDS = 80, W0 = 1, others 0.
  - Required: W16 = 1, W17 = 0, exactly 80 transfers, round_idx 0..79, then done.
- w_ready held low for 5 cycles while round_idx = 20.
  - Required: w_out and round_idx stable throughout, data_ready = 0, next word W21 correct after release.
- Back-to-back blocks, with the first word of block 2 presented in the cycle word 63 is taken.
  - Required: it is accepted, round_idx = 0 on the next cycle, and block 2's outputs are correct.
- Reset asserted at round 30.
  - Required: w_valid = 0, round_idx = 0, done = 0 immediately, and the next block is produced from round 0 correctly.
- MSG_EXP_ABORT_EN build, abort at round 40 coincident with w_ready.
  - Required: IDLE next cycle, no done pulse, and the following block is correct.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: sigma rotate/shift amounts, FSM states, window depth.
package sha2_pkg;

    localparam int WIN_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND
    } state_t;

    // k = 0: first rotate, k = 1: second rotate, k = 2: logical right shift
    function automatic int sigma_amt(input int word_w, input logic sel, input int k);
        int a0, a1, a2;
        if (word_w == 64) begin
            if (sel) begin a0 = 19; a1 = 61; a2 = 6; end
            else     begin a0 = 1;  a1 = 8;  a2 = 7; end
        end else begin
            if (sel) begin a0 = 17; a1 = 19; a2 = 10; end
            else     begin a0 = 7;  a1 = 18; a2 = 3;  end
        end
        case (k)
            0:       return a0;
            1:       return a1;
            default: return a2;
        endcase
    endfunction

endpackage

// File: rtl/sha2_sigma.sv
// SHA-2 small sigma function; sel = 0 gives sigma0, sel = 1 gives sigma1.
module sha2_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              sel,
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam int S0_A = sigma_amt(WORD_W, 1'b0, 0);
    localparam int S0_B = sigma_amt(WORD_W, 1'b0, 1);
    localparam int S0_C = sigma_amt(WORD_W, 1'b0, 2);
    localparam int S1_A = sigma_amt(WORD_W, 1'b1, 0);
    localparam int S1_B = sigma_amt(WORD_W, 1'b1, 1);
    localparam int S1_C = sigma_amt(WORD_W, 1'b1, 2);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int r);
        return (v >> r) | (v << (WORD_W - r));
    endfunction

    logic [WORD_W-1:0] sig0, sig1;

    assign sig0 = rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
    assign sig1 = rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
    assign y    = sel ? sig1 : sig0;

endmodule

// File: rtl/sha2_msg_expander.sv
// SHA-2 message schedule: loads 16 words, then expands to ROUNDS words with valid/ready on both sides.
// Optional abort input is enabled by defining MSG_EXP_ABORT_EN.
module sha2_msg_expander
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int RIDX_W = $clog2(ROUNDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [WORD_W-1:0] w_out,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [RIDX_W-1:0] round_idx,
    output logic              busy,
    output logic              done
`ifdef MSG_EXP_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam logic [RIDX_W-1:0] LOAD_LAST = RIDX_W'(WIN_DEPTH - 1);
    localparam logic [RIDX_W-1:0] RND_LAST  = RIDX_W'(ROUNDS - 1);

    state_t            state, state_nx;
    logic [WORD_W-1:0] win [WIN_DEPTH];
    logic [RIDX_W-1:0] rnd;
    logic              abort_i;
    logic              slot_free, accept, issue, take_last, win_shift;
    logic [WORD_W-1:0] s0, s1, w_new, win_in;

`ifdef MSG_EXP_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    sha2_sigma #(.WORD_W(WORD_W)) u_sig0 (.sel(1'b0), .x(win[1]),  .y(s0));
    sha2_sigma #(.WORD_W(WORD_W)) u_sig1 (.sel(1'b1), .x(win[14]), .y(s1));

    assign w_new = s1 + win[9] + s0 + win[0];
    assign busy  = (state != IDLE) || w_valid;

    always_comb begin
        slot_free  = !w_valid || w_ready;
        data_ready = slot_free && (state != EXPAND);
        accept     = data_valid && data_ready;
        issue      = (state == EXPAND) && slot_free;
        // the last word is only ever held after the FSM has already gone back to IDLE
        take_last  = w_valid && w_ready && (round_idx == RND_LAST);
        win_shift  = accept || issue;
        win_in     = accept ? data_in : w_new;
        state_nx   = state;
        case (state)
            IDLE:    if (accept) state_nx = LOAD;
            LOAD:    if (accept && rnd == LOAD_LAST) state_nx = EXPAND;
            EXPAND:  if (issue && rnd == RND_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort_i) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
        end else if (abort_i) begin
            for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
        end else if (win_shift) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) win[i] <= win[i+1];
            win[WIN_DEPTH-1] <= win_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_out     <= '0;
            w_valid   <= 1'b0;
            round_idx <= '0;
            rnd       <= '0;
            done      <= 1'b0;
        end else begin
            done <= take_last && !abort_i;
            if (abort_i) begin
                w_valid   <= 1'b0;
                round_idx <= '0;
                rnd       <= '0;
            end else if (accept) begin
                w_out     <= data_in;
                w_valid   <= 1'b1;
                round_idx <= (state == IDLE) ? '0 : rnd;
                rnd       <= (state == IDLE) ? RIDX_W'(1) : rnd + RIDX_W'(1);
            end else if (issue) begin
                w_out     <= w_new;
                w_valid   <= 1'b1;
                round_idx <= rnd;
                rnd       <= rnd + RIDX_W'(1);
            end else if (w_ready) begin
                w_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha2_msg_expander.sv
// Randomised scoreboard bench for sha2_msg_expander (SHA-256 instance plus a SHA-512 instance).
module tb_sha2_msg_expander;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] a_din, a_wout;
    logic        a_dvalid, a_dready, a_wvalid, a_wready, a_busy, a_done;
    logic [5:0]  a_ridx;
    logic [63:0] b_din, b_wout;
    logic        b_dvalid, b_dready, b_wvalid, b_wready, b_busy, b_done;
    logic [6:0]  b_ridx;
`ifdef MSG_EXP_ABORT_EN
    logic        a_abort, b_abort;
`endif

    sha2_msg_expander #(.WORD_W(32), .ROUNDS(64)) dut_a (
        .clk(clk), .reset(reset), .data_in(a_din), .data_valid(a_dvalid), .data_ready(a_dready),
        .w_out(a_wout), .w_valid(a_wvalid), .w_ready(a_wready), .round_idx(a_ridx),
        .busy(a_busy), .done(a_done)
`ifdef MSG_EXP_ABORT_EN
        , .abort(a_abort)
`endif
    );

    sha2_msg_expander #(.WORD_W(64), .ROUNDS(80)) dut_b (
        .clk(clk), .reset(reset), .data_in(b_din), .data_valid(b_dvalid), .data_ready(b_dready),
        .w_out(b_wout), .w_valid(b_wvalid), .w_ready(b_wready), .round_idx(b_ridx),
        .busy(b_busy), .done(b_done)
`ifdef MSG_EXP_ABORT_EN
        , .abort(b_abort)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] w;
        int          idx;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] msg   [16];
    logic [63:0] sched [80];
    logic [31:0] obs   [64];
    int          last_take_cyc = -1;
    int          first_acc_cyc = -1;
    logic        rand_rdy = 1'b0;

    // Reference model: textbook SHA-2 schedule recurrence on plain integers
    function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int w);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return ((x >> r) | (x << (w - r))) & m;
    endfunction

    function automatic logic [63:0] ssig(input int sel, input logic [63:0] x, input int w);
        if (w == 32)
            return sel ? (rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10))
                       : (rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3));
        return sel ? (rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6))
                   : (rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7));
    endfunction

    function automatic void build(input int w, input int n);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        for (int t = 0; t < n; t++) begin
            if (t < 16) sched[t] = msg[t] & m;
            else sched[t] = (ssig(1, sched[t-2], w) + sched[t-7] + ssig(0, sched[t-15], w) + sched[t-16]) & m;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor for the SHA-256 instance: pops the scoreboard on every output transfer
    initial begin
        logic done_exp;
        exp_t e;
        done_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_exp = 1'b0;
                continue;
            end
            chk("a_done", a_done, done_exp);
            done_exp = 1'b0;
            if (a_wvalid && a_wready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_extra_word actual=%h required=none", a_wout);
                end else begin
                    e = sb.pop_front();
                    chk("a_w", a_wout, e.w);
                    chk("a_idx", a_ridx, e.idx);
                    obs[a_ridx] = a_wout;
                    if (a_ridx == 6'd63) begin
                        last_take_cyc = cyc;
                        done_exp = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) a_wready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic rand_msg();
        for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    endtask

    task automatic send_a();
        int n;
        build(32, 64);
        for (int t = 0; t < 64; t++) sb.push_back('{sched[t], t});
        for (int i = 0; i < 16; i++) begin
            a_din    = msg[i][31:0];
            a_dvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!a_dready && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!a_dready) timeout("a_accept");
            if (i == 0) first_acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        a_dvalid = 1'b0;
        a_din    = $urandom;
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) timeout("a_drain");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_round(input int r);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(a_wvalid && a_ridx == r) && n < 300);
        if (!(a_wvalid && a_ridx == r)) timeout("a_wait_round");
    endtask

    task automatic send_b();
        int n;
        for (int i = 0; i < 16; i++) begin
            b_din    = msg[i];
            b_dvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!b_dready && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!b_dready) timeout("b_accept");
            @(posedge clk);
            #1;
        end
        b_dvalid = 1'b0;
    endtask

    task automatic check_b();
        int n;
        n = 0;
        for (int c = 0; c < 300 && n < 80; c++) begin
            @(negedge clk);
            if (b_wvalid && b_wready) begin
                chk("b_w", b_wout, sched[n]);
                chk("b_idx", b_ridx, n);
                if (n == 16) chk("b_w16", b_wout, 64'd1);
                if (n == 17) chk("b_w17", b_wout, 64'd0);
                n++;
            end
        end
        chk("b_count", n, 80);
        @(negedge clk);
        chk("b_done", b_done, 1'b1);
        chk("b_wvalid_after", b_wvalid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a_din = '0; a_dvalid = 1'b0; a_wready = 1'b1;
        b_din = '0; b_dvalid = 1'b0; b_wready = 1'b1;
`ifdef MSG_EXP_ABORT_EN
        a_abort = 1'b0; b_abort = 1'b0;
`endif
        #22;
        chk("rst_wout", a_wout, 0);
        chk("rst_wvalid", a_wvalid, 0);
        chk("rst_ridx", a_ridx, 0);
        chk("rst_done", a_done, 0);
        chk("rst_busy", a_busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_dready", a_dready, 1);
        @(posedge clk);
        #1;

        // "abc" block
        for (int i = 0; i < 16; i++) msg[i] = 0;
        msg[0]  = 64'h6162_6380;
        msg[15] = 64'h18;
        send_a();
        drain_a();
        chk("abc_w16", obs[16], 32'h6162_6380);
        chk("abc_w17", obs[17], 32'h000F_0000);
        chk("abc_latency", last_take_cyc - first_acc_cyc, 64);
        chk("abc_busy_end", a_busy, 0);

        // backpressure at round 20
        rand_msg();
        send_a();
        wait_round(20);
        a_wready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_w", a_wout, sched[20][31:0]);
            chk("stall_idx", a_ridx, 20);
            chk("stall_dready", a_dready, 0);
        end
        @(posedge clk);
        #1;
        a_wready = 1'b1;
        drain_a();

        // back-to-back blocks
        rand_msg();
        send_a();
        rand_msg();
        send_a();
        chk("b2b_accept_cycle", first_acc_cyc, last_take_cyc);
        drain_a();

        // random backpressure
        rand_rdy = 1'b1;
        repeat (3) begin
            rand_msg();
            send_a();
        end
        drain_a();
        rand_rdy = 1'b0;
        a_wready = 1'b1;
        drain_a();

        // reset mid-block
        rand_msg();
        send_a();
        wait_round(30);
        reset = 1'b1;
        #1;
        chk("mrst_wvalid", a_wvalid, 0);
        chk("mrst_ridx", a_ridx, 0);
        chk("mrst_done", a_done, 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rand_msg();
        send_a();
        drain_a();

`ifdef MSG_EXP_ABORT_EN
        rand_msg();
        send_a();
        wait_round(40);
        a_abort = 1'b1;
        @(posedge clk);
        #1;
        a_abort = 1'b0;
        sb.delete();
        chk("abort_wvalid", a_wvalid, 0);
        chk("abort_ridx", a_ridx, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_dready", a_dready, 1);
        repeat (3) @(posedge clk);
        #1;
        rand_msg();
        send_a();
        drain_a();
`endif

        // SHA-512 instance: single-bit message
        for (int i = 0; i < 16; i++) msg[i] = 0;
        msg[0] = 64'd1;
        build(64, 80);
        fork
            send_b();
            check_b();
        join
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
